// File: rtl/cu_if_fetch.sv
// cu_if_fetch: sequential instruction fetch with a small word buffer feeding decode.
// Optional IF_ALIGN_TRAP_EN: misaligned redirect sets misaligned_fetch and halts fetch.
module cu_if_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        soc_clk,
  input  logic        IF_reset,
  input  logic        IF_stall,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        IDU_ready,
  output logic        decode_start,
  output logic [31:0] Cu_IR,
  output logic [31:0] fetch_pc,
  output logic [2:0]  fifo_count
`ifdef IF_ALIGN_TRAP_EN
  ,
  output logic        misaligned_fetch
`endif
);

  localparam int          PW    = (FIFO_DEPTH == 4) ? 2 : 1;
  localparam logic [2:0]  DEPTH = 3'(FIFO_DEPTH);
  localparam logic [31:0] NOP   = 32'h0000_0013;

  typedef enum logic [1:0] {
    F_IDLE,
    F_REQ,
    F_DROP
  } fstate_t;

  fstate_t       r_state;
  fstate_t       w_state_nx;
  logic [31:0]   r_next_pc;
  logic [31:0]   w_next_pc_nx;
  logic [31:0]   r_drop_addr;
  logic          r_id_free;
  logic          r_decode_start;
  logic [31:0]   r_ir;
  logic [31:0]   r_pc;
  logic [31:0]   r_fifo_ir [FIFO_DEPTH];
  logic [31:0]   r_fifo_pc [FIFO_DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [2:0]    r_count;
  logic [2:0]    w_count_post;
  logic          w_push;
  logic          w_pop;
  logic          w_halt;
  logic          w_enter_drop;
  logic [31:0]   w_redir_pc;

  assign w_redir_pc = {redirect_pc[31:2], 2'b00};

`ifdef IF_ALIGN_TRAP_EN
  logic r_misaligned;
  logic w_misalign;

  assign w_misalign       = redirect_valid &
                            (redirect_pc[1:0] != 2'b00);
  assign w_halt           = r_misaligned;
  assign misaligned_fetch = r_misaligned;

  always_ff @(posedge soc_clk or posedge IF_reset) begin
    if (IF_reset) begin
      r_misaligned <= 1'b0;
    end else if (w_misalign) begin
      r_misaligned <= 1'b1;
    end
  end
`else
  logic w_unused_lsb;

  assign w_unused_lsb = ^redirect_pc[1:0];
  assign w_halt       = 1'b0;
`endif

  assign w_pop = (r_count != 3'd0) & r_id_free &
                 ~IF_stall & ~redirect_valid;

  // occupancy once this cycle's push lands, net of a same-cycle pop
  assign w_count_post = r_count + 3'd1 - {2'b00, w_pop};

  assign w_enter_drop = (r_state == F_REQ) &
                        redirect_valid & ~mem_ack;

  always_comb begin
    w_state_nx   = r_state;
    w_next_pc_nx = r_next_pc;
    w_push       = 1'b0;
    unique case (r_state)
      F_IDLE: begin
        if (redirect_valid) begin
          w_next_pc_nx = w_redir_pc;
        end else if ((r_count < DEPTH) && !w_halt) begin
          w_state_nx = F_REQ;
        end
      end
      F_REQ: begin
        if (mem_ack && redirect_valid) begin
          w_next_pc_nx = w_redir_pc;
          w_state_nx   = F_IDLE;
        end else if (mem_ack) begin
          w_push       = 1'b1;
          w_next_pc_nx = r_next_pc + 32'd4;
          w_state_nx   = (w_count_post < DEPTH) ? F_REQ : F_IDLE;
        end else if (redirect_valid) begin
          w_next_pc_nx = w_redir_pc;
          w_state_nx   = F_DROP;
        end
      end
      F_DROP: begin
        if (redirect_valid) begin
          w_next_pc_nx = w_redir_pc;
        end
        if (mem_ack) begin
          w_state_nx = F_IDLE;
        end
      end
      default: begin
        w_state_nx = F_IDLE;
      end
    endcase
  end

  always_ff @(posedge soc_clk or posedge IF_reset) begin
    if (IF_reset) begin
      r_state     <= F_IDLE;
      r_next_pc   <= RESET_PC;
      r_drop_addr <= RESET_PC;
    end else begin
      r_state   <= w_state_nx;
      r_next_pc <= w_next_pc_nx;
      if (w_enter_drop) begin
        r_drop_addr <= r_next_pc;
      end
    end
  end

  always_ff @(posedge soc_clk or posedge IF_reset) begin
    if (IF_reset) begin
      r_count <= 3'd0;
      r_wptr  <= '0;
      r_rptr  <= '0;
    end else if (redirect_valid) begin
      r_count <= 3'd0;
      r_wptr  <= '0;
      r_rptr  <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      r_count <= r_count + {2'b00, w_push} - {2'b00, w_pop};
    end
  end

  always_ff @(posedge soc_clk) begin
    if (w_push) begin
      r_fifo_ir[r_wptr] <= mem_rdata;
      r_fifo_pc[r_wptr] <= r_next_pc;
    end
  end

  // a pop beats a simultaneous IDU_ready, leaving decode busy
  always_ff @(posedge soc_clk or posedge IF_reset) begin
    if (IF_reset) begin
      r_decode_start <= 1'b0;
      r_ir           <= NOP;
      r_pc           <= RESET_PC;
      r_id_free      <= 1'b1;
    end else begin
      r_decode_start <= w_pop;
      if (w_pop) begin
        r_ir      <= r_fifo_ir[r_rptr];
        r_pc      <= r_fifo_pc[r_rptr];
        r_id_free <= 1'b0;
      end else if (IDU_ready) begin
        r_id_free <= 1'b1;
      end
    end
  end

  assign mem_req      = (r_state != F_IDLE);
  assign mem_addr     = (r_state == F_DROP) ? r_drop_addr
                                            : r_next_pc;
  assign decode_start = r_decode_start;
  assign Cu_IR        = r_ir;
  assign fetch_pc     = r_pc;
  assign fifo_count   = r_count;

endmodule
